mem_stage: RTL

- Memory-access stage of the 5-stage LoongArch pipeline. It sits between the EX/MEM pipeline register and WBReg.
- Issues load/store transactions to the data-memory bus over a valid/ready request with an rvalid response. Sign- or zero-extends load data and generates byte strobes for stores.
- Drives the WB-bound fields that WBReg captures. Asserts mem_stall so the hazard unit holds the front of the pipe while an access is outstanding.

---
 rtl/mem_pkg.sv | 14 +
 rtl/load_ext.sv | 18 +
 rtl/mem_stage.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory-access stage
package mem_pkg;
  typedef enum logic [2:0] {
    MOP_B  = 3'd0,
    MOP_H  = 3'd1,
    MOP_W  = 3'd2,
    MOP_BU = 3'd4,
    MOP_HU = 3'd5
  } mem_op_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  localparam logic [2:0] WD_ALU = 3'd0;
  localparam logic [2:0] WD_MEM = 3'd1;
  localparam logic [2:0] WD_PC4 = 3'd2;
endpackage

// File: rtl/load_ext.sv
// load_ext: selects the addressed byte/half of read data and sign/zero-extends it
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{lane, 3'b000} +: 8];
  assign h = lane[1] ? rdata[31:16] : rdata[15:0];
  assign data = op == MOP_B  ? {{24{b[7]}}, b}  :
                op == MOP_BU ? {24'd0, b}       :
                op == MOP_H  ? {{16{h[15]}}, h} :
                op == MOP_HU ? {16'd0, h}       : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: LoongArch MEM stage, valid/ready data bus master; optional MEM_ALIGN_CHECK_EN adds ale
module mem_stage
  import mem_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_flush,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        RegWrite_in,
  input  logic [2:0]  WDSel_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  mem_op_in,
  output logic        dm_req,
  input  logic        dm_req_ready,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] PC_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] dm_data_out,
  output logic [4:0]  rd_out,
  output logic        RegWrite_out,
  output logic [2:0]  WDSel_out,
  output logic        mem_stall,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        ale,
`endif
  output logic        bus_err
);
  state_t      state, state_n;
  logic        kill, kill_n;
  logic [31:0] cnt, req_addr, req_wdata, ext, wdata_c;
  logic        req_we, mem, mis, issue, tmo, done, pass;
  logic [3:0]  req_wstrb, wstrb_c;
  logic [2:0]  req_op;
  assign mem = valid_in & (MemRead_in | MemWrite_in);
`ifdef MEM_ALIGN_CHECK_EN
  assign mis = mem & ((mem_op_in[1:0] == 2'd1 & alu_result_in[0]) |
                      (mem_op_in[1:0] == 2'd2 & |alu_result_in[1:0]));
  assign ale = state == S_IDLE & mis & ~is_flush;
`else
  assign mis = 1'b0;
`endif
  assign wstrb_c = ~MemWrite_in ? 4'b0000 :
                   mem_op_in[1:0] == 2'd0 ? 4'b0001 << alu_result_in[1:0] :
                   mem_op_in[1:0] == 2'd1 ? (alu_result_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_c = mem_op_in[1:0] == 2'd0 ? {4{store_data_in[7:0]}} :
                   mem_op_in[1:0] == 2'd1 ? {2{store_data_in[15:0]}} : store_data_in;
  assign issue = state == S_IDLE & mem & ~is_flush & ~mis;
  assign tmo = RESP_TIMEOUT != 0 && state == S_RESP && !dm_rvalid && cnt == 32'(RESP_TIMEOUT - 1);
  assign done = state == S_RESP & (dm_rvalid | tmo);
  load_ext u_ext (.rdata(dm_rdata), .op(req_op), .lane(req_addr[1:0]), .data(ext));
  // Next state, kill tracking, bus request and WB-bound outputs
  always_comb begin
    state_n = issue ? (dm_req_ready ? S_RESP : S_REQ) :
              state == S_REQ && dm_req_ready ? S_RESP :
              done ? S_IDLE : state;
    kill_n = state != S_IDLE & ~done & (kill | is_flush);
    dm_req = issue | state == S_REQ;
    dm_we = state == S_IDLE ? MemWrite_in : req_we;
    dm_addr = state == S_IDLE ? {alu_result_in[31:2], 2'b00} : {req_addr[31:2], 2'b00};
    dm_wstrb = state == S_IDLE ? wstrb_c : req_wstrb;
    dm_wdata = state == S_IDLE ? wdata_c : req_wdata;
    mem_stall = state == S_IDLE ? issue : (kill | is_flush) ? kill & mem & ~is_flush : ~done;
    pass = (state == S_IDLE || kill) ? ~mem : state == S_RESP & dm_rvalid;
    RegWrite_out = valid_in & RegWrite_in & ~is_flush & pass;
    dm_data_out = state == S_RESP & dm_rvalid & ~kill & ~is_flush ? ext : 32'd0;
    bus_err = tmo;
    instr_out = instr_in;
    PC_out = PC_in;
    alu_result_out = alu_result_in;
    rd_out = rd_in;
    WDSel_out = WDSel_in;
  end
  // FSM, kill flag and response timer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      kill <= 1'b0;
      cnt <= 32'd0;
    end else begin
      state <= state_n;
      kill <= kill_n;
      cnt <= (state == S_RESP && state_n == S_RESP) ? cnt + 32'd1 : 32'd0;
    end
  end
  // Hold the request fields so they stay stable even if EX/MEM moves on after a flush
  always_ff @(posedge clk) begin
    if (issue) begin
      req_addr <= alu_result_in;
      req_we <= MemWrite_in;
      req_wstrb <= wstrb_c;
      req_wdata <= wdata_c;
      req_op <= mem_op_in;
    end
  end
endmodule
